// File: rtl/grn_sweep_ctrl.sv
// Sweeps every initial GRN state, iterating each to a fixed point or MAX_STEPS.
// Optional WAIT watchdog and res_timeout port: define GRN_SWEEP_TIMEOUT_EN.
module grn_sweep_ctrl #(
    parameter int N_GENES   = 5,
    parameter int MAX_STEPS = 16,
    parameter int STEP_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               grn_in_valid,
    output logic [N_GENES-1:0] grn_in_data,
    input  logic               grn_out_valid,
    input  logic [N_GENES-1:0] grn_out_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_GENES-1:0] res_init,
    output logic [N_GENES-1:0] res_final,
    output logic [STEP_W-1:0]  res_steps,
    output logic               res_fixed
`ifdef GRN_SWEEP_TIMEOUT_EN
    ,
    output logic               res_timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_GENES-1:0] init_q, init_d;
    logic [N_GENES-1:0] cur_q, cur_d;
    logic [N_GENES-1:0] fin_q, fin_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [STEP_W-1:0]  steps_inc;
    logic               fixed_q, fixed_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef GRN_SWEEP_TIMEOUT_EN
    logic               to_q, to_d;
    logic [3:0]         wd_q, wd_d;
`endif

    assign steps_inc = steps_q + STEP_W'(1);

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        cur_d   = cur_q;
        fin_d   = fin_q;
        steps_d = steps_q;
        fixed_d = fixed_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef GRN_SWEEP_TIMEOUT_EN
        to_d    = to_q;
        wd_d    = wd_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    init_d  = '0;
                    cur_d   = '0;
                    steps_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef GRN_SWEEP_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (grn_out_valid) begin
                    steps_d = steps_inc;
                    if (grn_out_data == cur_q) begin
                        fin_d   = grn_out_data;
                        fixed_d = 1'b1;
`ifdef GRN_SWEEP_TIMEOUT_EN
                        to_d    = 1'b0;
`endif
                        state_d = EMIT;
                    end else if (steps_inc == STEP_W'(MAX_STEPS)) begin
                        fin_d   = grn_out_data;
                        fixed_d = 1'b0;
`ifdef GRN_SWEEP_TIMEOUT_EN
                        to_d    = 1'b0;
`endif
                        state_d = EMIT;
                    end else begin
                        cur_d   = grn_out_data;
                        state_d = ISSUE;
                    end
                end
`ifdef GRN_SWEEP_TIMEOUT_EN
                // eighth silent WAIT cycle gives up on this trajectory
                else if (wd_q == 4'd7) begin
                    fin_d   = cur_q;
                    fixed_d = 1'b0;
                    to_d    = 1'b1;
                    state_d = EMIT;
                end else begin
                    wd_d = wd_q + 4'd1;
                end
`endif
            end
            EMIT: begin
                if (res_ready) begin
                    if (&init_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        init_d  = init_q + 1'b1;
                        cur_d   = init_q + 1'b1;
                        steps_d = '0;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            init_q  <= '0;
            cur_q   <= '0;
            fin_q   <= '0;
            steps_q <= '0;
            fixed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GRN_SWEEP_TIMEOUT_EN
            to_q    <= 1'b0;
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            cur_q   <= cur_d;
            fin_q   <= fin_d;
            steps_q <= steps_d;
            fixed_q <= fixed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GRN_SWEEP_TIMEOUT_EN
            to_q    <= to_d;
            wd_q    <= wd_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign grn_in_valid = (state_q == ISSUE);
    assign grn_in_data  = cur_q;
    assign res_valid    = (state_q == EMIT);
    assign res_init     = init_q;
    assign res_final    = fin_q;
    assign res_steps    = steps_q;
    assign res_fixed    = fixed_q;
`ifdef GRN_SWEEP_TIMEOUT_EN
    assign res_timeout  = to_q;
`endif

endmodule

// File: tb/tb_grn_sweep_ctrl.sv
// Bench for grn_sweep_ctrl: table-driven GRN stub with random latency,
// trajectory model per initial state, randomized consumer stalls.
module tb_grn_sweep_ctrl;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       grn_in_valid;
    logic [4:0] grn_in_data;
    logic       grn_out_valid;
    logic [4:0] grn_out_data;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_init;
    logic [4:0] res_final;
    logic [4:0] res_steps;
    logic       res_fixed;
`ifdef GRN_SWEEP_TIMEOUT_EN
    logic       res_timeout;
`endif

    grn_sweep_ctrl #(
        .N_GENES  (5),
        .MAX_STEPS(16),
        .STEP_W   (5)
    ) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .grn_in_valid (grn_in_valid),
        .grn_in_data  (grn_in_data),
        .grn_out_valid(grn_out_valid),
        .grn_out_data (grn_out_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_init     (res_init),
        .res_final    (res_final),
        .res_steps    (res_steps),
`ifdef GRN_SWEEP_TIMEOUT_EN
        .res_fixed    (res_fixed),
        .res_timeout  (res_timeout)
`else
        .res_fixed    (res_fixed)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // GRN next-state table and the expected outcome of one trajectory
    int tbl[32];

    typedef struct {
        int init;
        int fin;
        int steps;
        int fixed;
    } res_t;

    function automatic res_t model(input int init);
        res_t r;
        int   cur;
        int   nx;
        r.init  = init;
        r.fin   = 0;
        r.steps = 0;
        r.fixed = 0;
        cur     = init;
        for (int s = 1; s <= 16; s++) begin
            nx = tbl[cur];
            if (nx == cur) begin
                r.fin = nx; r.steps = s; r.fixed = 1;
                return r;
            end
            if (s == 16) begin
                r.fin = nx; r.steps = s; r.fixed = 0;
                return r;
            end
            cur = nx;
        end
        return r;
    endfunction

    // GRN stub: answers each strobe after 1+lat cycles; optional stray strobes
    bit   glitch_en = 0;
    bit   silent    = 0;
    int   max_lat   = 0;
    bit   pend      = 0;
    int   pdata     = 0;
    int   wcnt      = 0;
    logic iv;
    logic [4:0] id;

    always @(posedge tb_clk) begin
        iv = grn_in_valid;
        id = grn_in_data;
        #1;
        grn_out_valid = 1'b0;
        if (rst) begin
            pend = 0;
        end else if (iv && !silent) begin
            pend  = 1;
            pdata = tbl[id];
            wcnt  = $urandom_range(0, max_lat);
        end else if (pend && wcnt > 0) begin
            wcnt--;
        end
        if (pend && wcnt == 0) begin
            grn_out_valid = 1'b1;
            grn_out_data  = 5'(pdata);
            pend          = 0;
        end else if (!pend && !iv && glitch_en && $urandom_range(0, 3) == 0) begin
            grn_out_valid = 1'b1;
            grn_out_data  = 5'($urandom);
        end
    end

    // scoreboard
    res_t q[$];
    bit   chk_en     = 1;
    bit   exp_busy   = 0;
    bit   exp_done   = 0;
    bit   start_pend = 0;
    bit   acc_last   = 0;
    int   strobes    = 0;
    int   n_acc      = 0;
    int   first_init = -1;
    int   got_fin[32];
    int   got_steps[32];
    int   got_fix[32];
    int   got_strb[32];

    always @(negedge tb_clk) begin
        res_t r;
        if (rst) begin
            q.delete();
            exp_busy   = 0;
            exp_done   = 0;
            start_pend = 0;
            acc_last   = 0;
            strobes    = 0;
        end else if (chk_en) begin
            if (start_pend) begin
                exp_busy = 1;
                exp_done = 0;
                q.delete();
                for (int i = 0; i < 32; i++) q.push_back(model(i));
                start_pend = 0;
                strobes    = 0;
            end
            if (acc_last) begin
                exp_busy = 0;
                exp_done = 1;
                acc_last = 0;
            end
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            if (grn_in_valid) begin
                strobes++;
                if (!exp_busy) chk("strobe_when_idle", grn_in_valid, 0);
            end
            if (res_valid) begin
                chk("no_grn_in_emit", grn_in_valid, 0);
                if (q.size() == 0) begin
                    chk("unexpected_result", res_valid, 0);
                end else begin
                    r = q[0];
                    chk("res_init", res_init, r.init);
                    chk("res_final", res_final, r.fin);
                    chk("res_steps", res_steps, r.steps);
                    chk("res_fixed", res_fixed, r.fixed);
                    chk("strobe_count", strobes, r.steps);
`ifdef GRN_SWEEP_TIMEOUT_EN
                    chk("res_timeout", res_timeout, 0);
`endif
                    if (res_ready) begin
                        got_fin[r.init]   = res_final;
                        got_steps[r.init] = res_steps;
                        got_fix[r.init]   = res_fixed;
                        got_strb[r.init]  = strobes;
                        if (n_acc == 0) first_init = res_init;
                        n_acc++;
                        strobes = 0;
                        void'(q.pop_front());
                        if (q.size() == 0) acc_last = 1;
                    end
                end
            end
            if (start && !exp_busy) start_pend = 1;
        end
    end

    task automatic pulse_start;
        @(posedge tb_clk); #1;
        start = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int maxc, input bit rnd);
        bit hit;
        hit = 0;
        for (int c = 0; c < maxc && !hit; c++) begin
            @(posedge tb_clk); #1;
            if (done) hit = 1;
            start     = !hit && rnd && ($urandom_range(0, 40) == 0);
            res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        chk("sweep_finished", hit, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_grn_in_valid"}, grn_in_valid, 0);
        chk({nm, "_grn_in_data"}, grn_in_data, 0);
        chk({nm, "_res_valid"}, res_valid, 0);
        chk({nm, "_res_bus"}, {res_init, res_final, res_steps, res_fixed}, 0);
    endtask

    initial begin
        #900000;
        n_fail++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        res_t m;
        int   s;
        bit   hit;
        for (int i = 0; i < 32; i++) tbl[i] = $urandom_range(0, 31);
        tbl[0]  = 0;
        tbl[1]  = 0;
        tbl[2]  = 19;
        tbl[19] = 20;
        tbl[20] = 8;
        tbl[8]  = 2;
        rst           = 1'b1;
        start         = 1'b0;
        res_ready     = 1'b1;
        grn_out_valid = 1'b0;
        grn_out_data  = '0;

        repeat (3) @(posedge tb_clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        m = model(0);
        chk("model_i0", {m.fin, m.steps, m.fixed}, {32'd0, 32'd1, 32'd1});
        m = model(1);
        chk("model_i1", {m.fin, m.steps, m.fixed}, {32'd0, 32'd2, 32'd1});
        m = model(2);
        chk("model_i2", {m.fin, m.steps, m.fixed}, {32'd2, 32'd16, 32'd0});

        // first sweep: hold off the first result for 10 cycles
        res_ready = 1'b0;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge tb_clk); #1;
            if (res_valid) hit = 1;
        end
        chk("first_result_seen", hit, 1);
        chk("stall_init", res_init, 0);
        repeat (10) begin
            @(posedge tb_clk); #1;
            chk("stall_hold", res_valid, 1);
        end
        res_ready = 1'b1;
        @(posedge tb_clk); #1;
        chk("stall_release", res_valid, 0);
        chk("stall_accepted", n_acc, 1);
        run_until_done(15000, 0);
        chk("sweep1_count", n_acc, 32);
        chk("i0_result", {got_fin[0], got_steps[0], got_fix[0]}, {32'd0, 32'd1, 32'd1});
        chk("i1_result", {got_fin[1], got_steps[1], got_fix[1]}, {32'd0, 32'd2, 32'd1});
        chk("i2_result", {got_fin[2], got_steps[2], got_fix[2]}, {32'd2, 32'd16, 32'd0});
        chk("i2_strobes", got_strb[2], 16);
        chk("done_after_sweep", done, 1);
        chk("busy_after_sweep", busy, 0);
        s = 0;
        repeat (20) begin
            @(posedge tb_clk); #1;
            if (grn_in_valid || res_valid) s++;
        end
        chk("quiet_after_done", s, 0);

        // second sweep: random latency, stray GRN strobes, random stalls
        n_acc      = 0;
        first_init = -1;
        glitch_en  = 1;
        max_lat    = 3;
        pulse_start();
        run_until_done(15000, 1);
        chk("sweep2_count", n_acc, 32);
        chk("sweep2_first", first_init, 0);

        // reset while waiting on the GRN during init=5
        pulse_start();
        hit = 0;
        for (int c = 0; c < 5000 && !hit; c++) begin
            @(posedge tb_clk); #1;
            if (grn_in_valid && res_init == 5) hit = 1;
        end
        chk("reached_init5", hit, 1);
        @(posedge tb_clk); #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge tb_clk);
        #1;
        rst        = 1'b0;
        n_acc      = 0;
        first_init = -1;
        pulse_start();
        run_until_done(15000, 1);
        chk("sweep3_count", n_acc, 32);
        chk("sweep3_first", first_init, 0);

`ifdef GRN_SWEEP_TIMEOUT_EN
        // silent GRN: watchdog must emit after ISSUE plus 8 WAIT cycles
        chk_en    = 0;
        glitch_en = 0;
        silent    = 1;
        res_ready = 1'b0;
        rst       = 1'b1;
        @(posedge tb_clk); #1;
        rst = 1'b0;
        @(posedge tb_clk); #1;
        start = 1'b1;
        s     = 0;
        hit   = 0;
        for (int n = 1; n <= 20 && !hit; n++) begin
            @(posedge tb_clk); #1;
            start = 1'b0;
            if (res_valid) begin
                hit = 1;
                s   = n;
            end
        end
        chk("to_latency", s, 10);
        chk("to_init", res_init, 0);
        chk("to_flag", res_timeout, 1);
        chk("to_steps", res_steps, 0);
        chk("to_fixed", res_fixed, 0);
        chk("to_final", res_final, 0);
        res_ready = 1'b1;
        @(posedge tb_clk); #1;
        chk("to_continues", busy, 1);
        chk("to_next_init", res_init, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
